// File: rtl/matmul_chk_pkg.sv
// ---------------------------------------------------------------------------
// matmul_chk_pkg
// Shared types and helpers for the matmul read-data checker.
//   chk_state_t : run-state encoding (IDLE / RUN / DONE)
//   exp_entry_t : one expected read (data, mask, addr). The struct is sized
//                 to the largest supported widths. Narrower instances
//                 zero-extend into it, and the unused upper bits are constant
//                 and get trimmed.
//   sat_inc     : saturating increment used by every result counter
// ---------------------------------------------------------------------------
package matmul_chk_pkg;

  localparam int MAX_BUS_WIDTH  = 64;
  localparam int MAX_ADDR_WIDTH = 32;
  localparam int MAX_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  typedef struct packed {
    logic [MAX_BUS_WIDTH-1:0]  data;
    logic [MAX_BUS_WIDTH-1:0]  mask;
    logic [MAX_ADDR_WIDTH-1:0] addr;
  } exp_entry_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
    input logic [MAX_CNT_WIDTH-1:0] cnt,
    input logic [MAX_CNT_WIDTH-1:0] max_val
  );
    return (cnt == max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/matmul_chk_fifo.sv
// ---------------------------------------------------------------------------
// matmul_chk_fifo
// Synchronous show-ahead FIFO of expected entries with a registered head.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write request and entry (ignored while full)
//   pop          : consume the head (ignored while empty)
//   dout         : current head entry, valid whenever empty == 0
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module matmul_chk_fifo
  import matmul_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  exp_entry_t din,
  input  logic       pop,
  output exp_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  exp_entry_t       mem [DEPTH];
  exp_entry_t       head_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign dout       = head_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array and registered head read, kept free of reset so the
  // array maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // The head register always holds the entry that will be at the front after
  // this edge. When the only stored entry is popped while a new one is pushed,
  // the new entry has not reached the array yet, so it is forwarded from din.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      if (do_push && (rd_ptr_inc == wr_ptr_reg)) head_reg <= din;
      else                                       head_reg <= mem[rd_ptr_inc];
    end else if (empty && do_push) begin
      head_reg <= din;
    end
  end

endmodule

// File: rtl/matmul_rd_checker.sv
// ---------------------------------------------------------------------------
// matmul_rd_checker
// Monitors APB read completions and checks each one against a queue of
// expected entries (data, mask, addr). It counts hits, misses and underflows
// over an armed run of 'total' reads.
//   clk, rst                 : clock, synchronous active-high reset
//   exp_valid/exp_ready      : expected-entry push handshake
//   exp_data/exp_mask/exp_addr : expected entry contents
//   psel/penable/pwrite/pready/paddr/prdata : monitored APB bus
//   start, total             : arm pulse and number of reads to check
//   addr_chk_en              : include paddr in the compare
//   busy, done               : run status
//   hit_cnt/miss_cnt/underflow_cnt : saturating result counters
//   err                      : sticky miss/underflow flag
//   first_miss_addr/exp/got  : capture of the first miss after start
// BUS_WIDTH <= 64, ADDR_WIDTH <= 32, CNT_WIDTH <= 32.
// ---------------------------------------------------------------------------
module matmul_rd_checker
  import matmul_chk_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [BUS_WIDTH-1:0]  exp_data,
  input  logic [BUS_WIDTH-1:0]  exp_mask,
  input  logic [ADDR_WIDTH-1:0] exp_addr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic                  pready,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [BUS_WIDTH-1:0]  prdata,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  total,
  input  logic                  addr_chk_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  underflow_cnt,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] first_miss_addr,
  output logic [BUS_WIDTH-1:0]  first_miss_exp,
  output logic [BUS_WIDTH-1:0]  first_miss_got
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  chk_state_t              state_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [CNT_WIDTH-1:0]    hit_cnt_reg;
  logic [CNT_WIDTH-1:0]    miss_cnt_reg;
  logic [CNT_WIDTH-1:0]    underflow_cnt_reg;
  logic [CNT_WIDTH-1:0]    checked_reg;
  logic [CNT_WIDTH-1:0]    total_reg;
  logic                    err_reg;
  logic [ADDR_WIDTH-1:0]   fm_addr_reg;
  logic [BUS_WIDTH-1:0]    fm_exp_reg;
  logic [BUS_WIDTH-1:0]    fm_got_reg;

  exp_entry_t              push_entry;
  exp_entry_t              head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    completion;
  logic                    check_now;
  logic [MAX_BUS_WIDTH-1:0] prdata_ext;
  logic [MAX_BUS_WIDTH-1:0] bit_bad;
  logic                    data_ok;
  logic                    addr_ok;
  logic                    is_match;
  logic                    last_read;

  // ---------------- expected-entry FIFO ----------------
  assign push_entry.data = MAX_BUS_WIDTH'(exp_data);
  assign push_entry.mask = MAX_BUS_WIDTH'(exp_mask);
  assign push_entry.addr = MAX_ADDR_WIDTH'(exp_addr);

  assign exp_ready = ~fifo_full;
  assign fifo_push = exp_valid & ~fifo_full;

  // A start pulse re-arms the checker, and a completion on that same edge
  // belongs to neither run, so it is not consumed.
  assign completion = psel & penable & pready & ~pwrite;
  assign check_now  = (state_reg == RUN) & ~start & completion;
  assign fifo_pop   = check_now & ~fifo_empty;

  matmul_chk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- compare ----------------
  assign prdata_ext = MAX_BUS_WIDTH'(prdata);

  for (genvar gi = 0; gi < MAX_BUS_WIDTH; gi++) begin : g_cmp
    assign bit_bad[gi] = head.mask[gi] & (head.data[gi] ^ prdata_ext[gi]);
  end

  assign data_ok   = (bit_bad == '0);
  assign addr_ok   = ~addr_chk_en | (MAX_ADDR_WIDTH'(paddr) == head.addr);
  assign is_match  = data_ok & addr_ok;
  assign last_read = ((checked_reg + CNT_WIDTH'(1)) == total_reg);

  // ---------------- run FSM, counters and capture ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      hit_cnt_reg       <= '0;
      miss_cnt_reg      <= '0;
      underflow_cnt_reg <= '0;
      checked_reg       <= '0;
      total_reg         <= '0;
      err_reg           <= 1'b0;
      fm_addr_reg       <= '0;
      fm_exp_reg        <= '0;
      fm_got_reg        <= '0;
    end else if (start) begin
      hit_cnt_reg       <= '0;
      miss_cnt_reg      <= '0;
      underflow_cnt_reg <= '0;
      checked_reg       <= '0;
      total_reg         <= total;
      err_reg           <= 1'b0;
      fm_addr_reg       <= '0;
      fm_exp_reg        <= '0;
      fm_got_reg        <= '0;
      // An empty run has nothing to wait for, in whatever state it is armed.
      if (total == '0) begin
        state_reg <= DONE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
      end else begin
        state_reg <= RUN;
        busy_reg  <= 1'b1;
        done_reg  <= 1'b0;
      end
    end else if (check_now) begin
      if (fifo_empty) begin
        underflow_cnt_reg <= CNT_WIDTH'(sat_inc(32'(underflow_cnt_reg), 32'(CNT_MAX)));
        err_reg           <= 1'b1;
      end else if (is_match) begin
        hit_cnt_reg <= CNT_WIDTH'(sat_inc(32'(hit_cnt_reg), 32'(CNT_MAX)));
      end else begin
        miss_cnt_reg <= CNT_WIDTH'(sat_inc(32'(miss_cnt_reg), 32'(CNT_MAX)));
        err_reg      <= 1'b1;
        // A saturating counter never returns to zero, so zero means no miss
        // has been seen since start.
        if (miss_cnt_reg == '0) begin
          fm_addr_reg <= paddr;
          fm_exp_reg  <= head.data[BUS_WIDTH-1:0];
          fm_got_reg  <= prdata;
        end
      end
      // checked_reg is below total_reg (itself <= all-ones) and cannot wrap.
      checked_reg <= checked_reg + CNT_WIDTH'(1);
      if (last_read) begin
        state_reg <= DONE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
      end
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign hit_cnt         = hit_cnt_reg;
  assign miss_cnt        = miss_cnt_reg;
  assign underflow_cnt   = underflow_cnt_reg;
  assign err             = err_reg;
  assign first_miss_addr = fm_addr_reg;
  assign first_miss_exp  = fm_exp_reg;
  assign first_miss_got  = fm_got_reg;

endmodule

// File: tb/tb_matmul_rd_checker.sv
// ---------------------------------------------------------------------------
// tb_matmul_rd_checker
// Scoreboard bench: each clocked step runs a behavioural model of the
// checker, pushes the expected output snapshot to a queue, then pops it and
// compares it with the DUT one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_matmul_rd_checker;

  localparam int BW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          exp_valid;
  logic          exp_ready;
  logic [BW-1:0] exp_data;
  logic [BW-1:0] exp_mask;
  logic [AW-1:0] exp_addr;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [BW-1:0] prdata;
  logic          start;
  logic [CW-1:0] total;
  logic          addr_chk_en;
  logic          busy, done, err;
  logic [CW-1:0] hit_cnt, miss_cnt, underflow_cnt;
  logic [AW-1:0] first_miss_addr;
  logic [BW-1:0] first_miss_exp, first_miss_got;

  always #5 clk = ~clk;

  matmul_rd_checker #(
    .BUS_WIDTH  (BW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .exp_valid       (exp_valid),
    .exp_ready       (exp_ready),
    .exp_data        (exp_data),
    .exp_mask        (exp_mask),
    .exp_addr        (exp_addr),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .pready          (pready),
    .paddr           (paddr),
    .prdata          (prdata),
    .start           (start),
    .total           (total),
    .addr_chk_en     (addr_chk_en),
    .busy            (busy),
    .done            (done),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt),
    .underflow_cnt   (underflow_cnt),
    .err             (err),
    .first_miss_addr (first_miss_addr),
    .first_miss_exp  (first_miss_exp),
    .first_miss_got  (first_miss_got)
  );

  typedef struct {
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
    logic [AW-1:0] addr;
  } ent_t;

  typedef struct {
    bit            busy;
    bit            done;
    bit            err;
    int            hit;
    int            miss;
    int            unf;
    logic [AW-1:0] fa;
    logic [BW-1:0] fe;
    logic [BW-1:0] fg;
  } snap_t;

  // model state
  ent_t          mq[$];
  snap_t         sbq[$];
  int            m_state;   // 0 idle, 1 run, 2 done
  int            m_hit, m_miss, m_unf, m_checked, m_total;
  bit            m_err;
  logic [AW-1:0] m_fa;
  logic [BW-1:0] m_fe, m_fg;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic model_clear();
    m_hit = 0; m_miss = 0; m_unf = 0; m_checked = 0; m_err = 0;
    m_fa = '0; m_fe = '0; m_fg = '0;
  endtask

  // One clock: model the coming edge, queue the expectation, clock, compare.
  task automatic step();
    bit    comp;
    bit    do_push;
    ent_t  h;
    ent_t  e;
    snap_t s;
    comp    = psel && penable && pready && !pwrite;
    do_push = exp_valid && (mq.size() < DEPTH);
    check("exp_ready", 64'(exp_ready), 64'(mq.size() < DEPTH));
    if (rst) begin
      mq.delete();
      m_state = 0;
      m_total = 0;
      model_clear();
    end else begin
      if (start) begin
        model_clear();
        m_total = int'(total);
        m_state = (total == 0) ? 2 : 1;
      end else if (m_state == 1 && comp) begin
        if (mq.size() == 0) begin
          m_unf = sat(m_unf);
          m_err = 1;
        end else begin
          h = mq.pop_front();
          if ((((prdata ^ h.data) & h.mask) == 0) && (!addr_chk_en || paddr == h.addr))
            m_hit = sat(m_hit);
          else begin
            if (m_miss == 0) begin
              m_fa = paddr; m_fe = h.data; m_fg = prdata;
            end
            m_miss = sat(m_miss);
            m_err  = 1;
          end
        end
        m_checked++;
        if (m_checked == m_total) m_state = 2;
      end
      if (do_push) begin
        e.data = exp_data; e.mask = exp_mask; e.addr = exp_addr;
        mq.push_back(e);
      end
    end
    s.busy = (m_state == 1); s.done = (m_state == 2); s.err = m_err;
    s.hit = m_hit; s.miss = m_miss; s.unf = m_unf;
    s.fa = m_fa; s.fe = m_fe; s.fg = m_fg;
    sbq.push_back(s);

    @(posedge clk);
    #1;

    s = sbq.pop_front();
    check("busy",            64'(busy),            64'(s.busy));
    check("done",            64'(done),            64'(s.done));
    check("err",             64'(err),             64'(s.err));
    check("hit_cnt",         64'(hit_cnt),         64'(s.hit));
    check("miss_cnt",        64'(miss_cnt),        64'(s.miss));
    check("underflow_cnt",   64'(underflow_cnt),   64'(s.unf));
    check("first_miss_addr", 64'(first_miss_addr), 64'(s.fa));
    check("first_miss_exp",  64'(first_miss_exp),  64'(s.fe));
    check("first_miss_got",  64'(first_miss_got),  64'(s.fg));
  endtask

  task automatic push_e(input logic [BW-1:0] d, input logic [BW-1:0] m, input logic [AW-1:0] a);
    exp_valid = 1'b1; exp_data = d; exp_mask = m; exp_addr = a;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic do_start(input int t);
    start = 1'b1; total = CW'(t);
    step();
    start = 1'b0;
  endtask

  // APB read: setup, one wait state, then the completing access phase.
  // pv drives exp_valid during the completing phase and leaves it as set.
  task automatic apb_read(input logic [AW-1:0] a, input logic [BW-1:0] d, input bit pv);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; pready = 1'b0; paddr = a; prdata = d;
    step();
    penable = 1'b1;
    step();
    pready = 1'b1; exp_valid = pv;
    step();
    psel = 1'b0; penable = 1'b0; pready = 1'b0;
    $display("read addr=%h data=%h -> hit=%0d miss=%0d unf=%0d busy=%0b done=%0b err=%0b",
             a, d, hit_cnt, miss_cnt, underflow_cnt, busy, done, err);
  endtask

  initial begin
    rst = 1'b1; exp_valid = 1'b0; exp_data = '0; exp_mask = '0; exp_addr = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pready = 1'b0; paddr = '0; prdata = '0;
    start = 1'b0; total = '0; addr_chk_en = 1'b0;
    m_state = 0; m_total = 0; model_clear();
    repeat (2) @(posedge clk);
    #1;
    step();                       // reset state
    rst = 1'b0;
    step();

    // all-hit run of four reads
    for (int i = 0; i < 4; i++) push_e(32'h11 * (i + 1), '1, AW'(4 * i));
    do_start(4);
    for (int i = 0; i < 4; i++) apb_read(AW'(4 * i), 32'h11 * (i + 1), 1'b0);
    step();
    apb_read(16'h0000, 32'h11, 1'b0);   // ignored while DONE

    // first-miss capture, later miss leaves the capture alone
    for (int i = 0; i < 4; i++) push_e(32'h11 * (i + 1), '1, AW'(4 * i));
    do_start(4);
    apb_read(16'h0000, 32'h11, 1'b0);
    apb_read(16'h0004, 32'h23, 1'b0);
    apb_read(16'h0008, 32'h33, 1'b0);
    apb_read(16'h000C, 32'h40, 1'b0);

    // masked compare, then address compare
    push_e(32'h1234ABCD, 32'h0000FFFF, 16'h0010);
    push_e(32'h1234ABCD, 32'h0000FFFF, 16'h0010);
    do_start(2);
    apb_read(16'h0020, 32'hFFFFABCD, 1'b0);
    addr_chk_en = 1'b1;
    apb_read(16'h0014, 32'hFFFFABCD, 1'b0);
    addr_chk_en = 1'b0;

    // fill to full, pop with a simultaneous push attempt
    for (int i = 0; i < DEPTH; i++) push_e(32'h100 + i, '1, AW'(16'h100 + i));
    exp_data = 32'h1FF; exp_mask = '1; exp_addr = 16'h01FF;
    do_start(1);
    apb_read(16'h0100, 32'h100, 1'b1);  // blocked: FIFO full on this edge
    step();                              // slot now free: accepted
    exp_valid = 1'b0;
    step();                              // full again
    do_start(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      ent_t h;
      h = mq[0];
      apb_read(h.addr, h.data, 1'b0);
    end

    // underflow run on an empty FIFO
    do_start(3);
    for (int i = 0; i < 3; i++) apb_read(AW'(16'h0200 + 4 * i), 32'hDEAD0000 + i, 1'b0);
    step();

    // push and completion on an empty FIFO: underflow, entry kept
    exp_data = 32'h55; exp_mask = '1; exp_addr = 16'h0300;
    do_start(2);
    apb_read(16'h0300, 32'h55, 1'b1);
    exp_valid = 1'b0;
    apb_read(16'h0300, 32'h55, 1'b0);

    // zero-length run, then a run abandoned by reset
    do_start(0);
    push_e(32'h77, '1, 16'h0400);
    do_start(5);
    apb_read(16'h0400, 32'h78, 1'b0);
    rst = 1'b1; start = 1'b1; total = CW'(3);
    step();
    rst = 1'b0; start = 1'b0;
    step();
    apb_read(16'h0400, 32'h77, 1'b0);   // ignored in IDLE

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/matmul_rd_checker.md
MATMUL_RD_CHECKER -- requirements
Module: matmul_rd_checker

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: APB read-data and expected-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: APB and expected-address width.
REQ-003 SHALL have parameter DEPTH, default 8: expected-entry FIFO depth; power of 2, at least 2.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of all counters and of total.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-008 SHALL have port exp_valid, in, 1, and port exp_ready, out, 1: expected-entry push handshake.
REQ-009 SHALL have ports exp_data, in, BUS_WIDTH; exp_mask, in, BUS_WIDTH; exp_addr, in, ADDR_WIDTH: expected entry contents.
REQ-010 SHALL have ports psel, penable, pwrite, pready, in, 1 each: monitored APB strobes.
REQ-011 SHALL have ports paddr, in, ADDR_WIDTH, and prdata, in, BUS_WIDTH: monitored APB address and read data.
REQ-012 SHALL have port start, in, 1: arm or re-arm pulse.
REQ-013 SHALL have port total, in, CNT_WIDTH: number of reads to check, sampled on start.
REQ-014 SHALL have port addr_chk_en, in, 1: include the address in the compare.
REQ-015 SHALL have ports busy, out, 1, and done, out, 1: run status.
REQ-016 SHALL have ports hit_cnt, miss_cnt, underflow_cnt, out, CNT_WIDTH each: result counters.
REQ-017 SHALL have port err, out, 1: sticky flag, set on any miss or underflow.
REQ-018 SHALL have ports first_miss_addr, out, ADDR_WIDTH; first_miss_exp, out, BUS_WIDTH; first_miss_got, out, BUS_WIDTH: first-miss capture.

Function
REQ-019 SHALL treat a read completion as psel & penable & pready & ~pwrite sampled at a rising clk edge.
REQ-020 SHALL implement FSM IDLE/RUN/DONE with these transitions:
- IDLE: start and total==0 -> DONE; start otherwise -> RUN.
- RUN: -> DONE on the edge at which checked count reaches total.
- DONE: start -> RUN.
REQ-021 SHALL, on start in any state, clear all counters, err and capture registers, and latch total; FIFO contents are retained.
REQ-022 SHALL ignore read completions in IDLE and DONE: no pop, no count.
REQ-023 SHALL, in RUN, pop the FIFO head on each completion and count it as a hit or a miss.
- Match iff ((prdata ^ exp_data) & exp_mask) == 0 and (~addr_chk_en or paddr == exp_addr).
REQ-024 SHALL, on a completion in RUN with the FIFO empty, increment underflow_cnt and set err.
- It counts toward total but is neither a hit nor a miss.
REQ-025 SHALL set exp_ready = ~full and push an entry when exp_valid & exp_ready, in any state.
REQ-026 SHALL not bypass the FIFO: a push and a completion in the same cycle with the FIFO empty is an underflow, and the pushed entry is kept.
REQ-027 SHALL allow a push and a pop in the same cycle when the FIFO is non-empty and not full; occupancy is unchanged.
REQ-028 SHALL make counters saturate at all-ones and never wrap; the checked count still reaches total.
REQ-029 SHALL load first_miss_* only on the first miss after start and hold them until the next start or rst.
REQ-030 SHALL drive busy = (state == RUN) and done = (state == DONE).
REQ-031 SHALL make every counter, flag and state update visible one cycle after the causing edge; all outputs are registered except exp_ready.

Reset
REQ-032 SHALL, while rst is high, enter IDLE, empty the FIFO and drive to 0: busy, done, err, all counters and all first_miss_*.
REQ-033 SHALL give rst priority over start, pushes and completions in the same cycle; a mid-run rst abandons the run.

Structure
REQ-034 SHALL place in package matmul_chk_pkg: the state enum (IDLE, RUN, DONE), the expected-entry struct (data, mask, addr) and the counter-saturation helper.
REQ-035 SHALL implement the FIFO as sub-module matmul_chk_fifo (sync, DEPTH entries, full/empty flags, registered output).

Verification
REQ-036 SHALL cover: push 4 entries {0x11,0x22,0x33,0x44}, mask all-ones; start with total=4; return matching prdata -> hit_cnt=4, miss_cnt=0, done=1, err=0.
REQ-037 SHALL cover: second read returns 0x23 against expected 0x22 at paddr 0x0004 -> miss_cnt=1, err=1, first_miss_addr=0x0004, first_miss_exp=0x22, first_miss_got=0x23; a later miss leaves capture unchanged.
REQ-038 SHALL cover: mask 0x0000FFFF, exp 0x1234ABCD, prdata 0xFFFFABCD -> hit; with addr_chk_en=1 and paddr differing -> miss.
REQ-039 SHALL cover: push DEPTH entries -> exp_ready=0; one completion plus simultaneous push -> exactly one entry accepted after the pop frees a slot.
REQ-040 SHALL cover: start total=3 with empty FIFO and 3 completions -> underflow_cnt=3, DONE; rst mid-run -> IDLE, all outputs 0.
